mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction-cache, data-cache and unified-memory signals
// handled by mem_arbiter. The arbiter takes the slave view, the caches/memory the master view.
interface mem_arbiter_if;
  logic         I_READ;
  logic [5:0]   I_ADDRESS;
  logic [127:0] I_READDATA;
  logic         I_BUSYWAIT;
  logic         D_READ;
  logic         D_WRITE;
  logic [5:0]   D_ADDRESS;
  logic [31:0]  D_WRITEDATA;
  logic [31:0]  D_READDATA;
  logic         D_BUSYWAIT;
  logic         M_READ;
  logic         M_WRITE;
  logic [8:0]   M_ADDRESS;
  logic [31:0]  M_WRITEDATA;
  logic [31:0]  M_READDATA;
  logic         M_BUSYWAIT;

  modport slave (
    input  I_READ, I_ADDRESS, D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
           M_READDATA, M_BUSYWAIT,
    output I_READDATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
           M_READ, M_WRITE, M_ADDRESS, M_WRITEDATA
  );

  modport master (
    output I_READ, I_ADDRESS, D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
           M_READDATA, M_BUSYWAIT,
    input  I_READDATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
           M_READ, M_WRITE, M_ADDRESS, M_WRITEDATA
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one unified word-wide memory between a data cache (single word
// read/write) and an instruction cache (four-beat block read), alternating on ties.
module mem_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic         CLK,
  input  logic         RESET,
  mem_arbiter_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_D_ACC  = 3'd1;
  localparam logic [2:0] S_I_ACC  = 3'd2;
  localparam logic [2:0] S_DONE_D = 3'd3;
  localparam logic [2:0] S_DONE_I = 3'd4;

  // Pretending the other side won last makes DATA_FIRST pick the first tie.
  localparam logic LAST_D_RST = ~DATA_FIRST;

  logic [2:0]   state_q, state_d;
  logic [1:0]   beat_q, beat_d;
  logic         last_d_q, last_d_d;
  logic         m_read_q, m_read_d;
  logic         m_write_q, m_write_d;
  logic [8:0]   m_addr_q, m_addr_d;
  logic [31:0]  m_wdata_q, m_wdata_d;
  logic [31:0]  d_rdata_q, d_rdata_d;
  logic [127:0] i_rdata_q, i_rdata_d;
  logic         d_req_s;
  logic         i_req_s;
  logic         mem_done_s;

  assign d_req_s    = bus.D_READ | bus.D_WRITE;
  assign i_req_s    = bus.I_READ;
  assign mem_done_s = (m_read_q | m_write_q) & ~bus.M_BUSYWAIT;

  assign bus.D_BUSYWAIT  = RESET & d_req_s & (state_q != S_DONE_D);
  assign bus.I_BUSYWAIT  = RESET & i_req_s & (state_q != S_DONE_I);
  assign bus.M_READ      = m_read_q;
  assign bus.M_WRITE     = m_write_q;
  assign bus.M_ADDRESS   = m_addr_q;
  assign bus.M_WRITEDATA = m_wdata_q;
  assign bus.D_READDATA  = d_rdata_q;
  assign bus.I_READDATA  = i_rdata_q;

  // Next-state, memory strobes and read-data capture.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    last_d_d  = last_d_q;
    m_read_d  = m_read_q;
    m_write_d = m_write_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    d_rdata_d = d_rdata_q;
    i_rdata_d = i_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (d_req_s && (!i_req_s || !last_d_q)) begin
          state_d   = S_D_ACC;
          m_write_d = bus.D_WRITE;
          m_read_d  = ~bus.D_WRITE;
          m_addr_d  = {1'b1, 2'b00, bus.D_ADDRESS};
          m_wdata_d = bus.D_WRITEDATA;
        end else if (i_req_s) begin
          state_d   = S_I_ACC;
          beat_d    = 2'd0;
          m_read_d  = 1'b1;
          m_write_d = 1'b0;
          m_addr_d  = {1'b0, bus.I_ADDRESS, 2'b00};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_D_ACC: begin
        if (mem_done_s) begin
          state_d   = S_DONE_D;
          last_d_d  = 1'b1;
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          if (m_read_q) begin
            d_rdata_d = bus.M_READDATA;
          end else begin
            d_rdata_d = d_rdata_q;
          end
        end else begin
          state_d = S_D_ACC;
        end
      end
      S_I_ACC: begin
        if (mem_done_s) begin
          i_rdata_d[{beat_q, 5'd0} +: 32] = bus.M_READDATA;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d  = S_DONE_I;
            last_d_d = 1'b0;
            m_read_d = 1'b0;
          end else begin
            // Block index is still in m_addr_q[7:2]; only the beat field moves.
            m_addr_d = {m_addr_q[8:2], beat_q + 2'd1};
          end
        end else begin
          state_d = S_I_ACC;
        end
      end
      S_DONE_D, S_DONE_I: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        m_read_d  = 1'b0;
        m_write_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      beat_q    <= 2'd0;
      last_d_q  <= LAST_D_RST;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= 9'd0;
      m_wdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
      i_rdata_q <= 128'd0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      last_d_q  <= last_d_d;
      m_read_q  <= m_read_d;
      m_write_q <= m_write_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      d_rdata_q <= d_rdata_d;
      i_rdata_q <= i_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester tasks push expected memory
// transfers and read data; a negedge monitor pops and compares them.
module tb_mem_arbiter;

  typedef struct {
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] wd;
  } mtx_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   stall_n = 0;
  int   wait_cnt;
  int   wr_cycles = 0;

  mtx_t         mem_d_q[$];
  mtx_t         mem_i_q[$];
  logic [31:0]  d_exp_q[$];
  logic [127:0] i_exp_q[$];
  logic [31:0]  d_model = 32'd0;

  mem_arbiter_if bus();

  mem_arbiter #(.DATA_FIRST(1'b1)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [8:0] a);
    if (a == 9'h105) return 32'hA1B2C3D4;
    return {16'hC0DE, 7'd0, a};
  endfunction

  function automatic logic [127:0] block_of(input logic [5:0] a);
    return {mem_word({1'b0, a, 2'd3}), mem_word({1'b0, a, 2'd2}),
            mem_word({1'b0, a, 2'd1}), mem_word({1'b0, a, 2'd0})};
  endfunction

  // Memory model: stalls the first stall_n cycles of every transfer.
  assign bus.M_READDATA = mem_word(bus.M_ADDRESS);
  assign bus.M_BUSYWAIT = (bus.M_READ | bus.M_WRITE) && (wait_cnt < stall_n);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if ((bus.M_READ | bus.M_WRITE) && bus.M_BUSYWAIT) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after dropping the request.
  task automatic d_access(input logic wr, input logic [5:0] a, input logic [31:0] wd,
                          input int exp_lat);
    mtx_t t;
    int   lat;
    logic busy;
    t.wr = wr; t.addr = {1'b1, 2'b00, a}; t.wd = wd;
    mem_d_q.push_back(t);
    if (!wr) d_model = mem_word(t.addr);
    d_exp_q.push_back(d_model);
    bus.D_WRITE = wr; bus.D_READ = ~wr; bus.D_ADDRESS = a; bus.D_WRITEDATA = wd;
    lat = 0; busy = 1'b1;
    while (busy && lat < 100) begin
      @(negedge clk);
      busy = bus.D_BUSYWAIT || !rst_n;
      @(posedge clk);
      lat++;
    end
    #1 bus.D_READ = 1'b0; bus.D_WRITE = 1'b0;
    if (busy) check("d_timeout", 160'(lat), 160'd0);
    else if (exp_lat >= 0) check("d_latency", 160'(lat), 160'(exp_lat));
  endtask

  task automatic i_access(input logic [5:0] a, input int exp_lat);
    mtx_t t;
    int   lat;
    logic busy;
    for (int k = 0; k < 4; k++) begin
      t.wr = 1'b0; t.addr = {1'b0, a, 2'(k)}; t.wd = 32'd0;
      mem_i_q.push_back(t);
    end
    i_exp_q.push_back(block_of(a));
    bus.I_READ = 1'b1; bus.I_ADDRESS = a;
    lat = 0; busy = 1'b1;
    while (busy && lat < 100) begin
      @(negedge clk);
      busy = bus.I_BUSYWAIT || !rst_n;
      @(posedge clk);
      lat++;
    end
    #1 bus.I_READ = 1'b0;
    if (busy) check("i_timeout", 160'(lat), 160'd0);
    else if (exp_lat >= 0) check("i_latency", 160'(lat), 160'(exp_lat));
  endtask

  // Monitor: memory transfers, data completions and instruction completions.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.M_READ | bus.M_WRITE) begin
        if (bus.M_WRITE) wr_cycles <= wr_cycles + 1;
        if (bus.M_ADDRESS[8] ? (mem_d_q.size() == 0) : (mem_i_q.size() == 0)) begin
          check("m_unexpected", {150'd0, bus.M_WRITE, bus.M_ADDRESS}, 160'd0);
        end else begin
          mtx_t t;
          t = bus.M_ADDRESS[8] ? mem_d_q[0] : mem_i_q[0];
          check("m_xfer", {bus.M_READ, bus.M_WRITE, bus.M_ADDRESS,
                           t.wr ? bus.M_WRITEDATA : 32'd0},
                          {~t.wr, t.wr, t.addr, t.wr ? t.wd : 32'd0});
          if (!bus.M_BUSYWAIT) begin
            if (bus.M_ADDRESS[8]) void'(mem_d_q.pop_front());
            else void'(mem_i_q.pop_front());
          end
        end
      end
      if ((bus.D_READ | bus.D_WRITE) && !bus.D_BUSYWAIT) begin
        if (d_exp_q.size() == 0) check("d_unexpected", 160'(bus.D_READDATA), 160'd0);
        else check("d_rdata", 160'(bus.D_READDATA), 160'(d_exp_q.pop_front()));
      end
      if (bus.I_READ && !bus.I_BUSYWAIT) begin
        if (i_exp_q.size() == 0) check("i_unexpected", 160'(bus.I_READDATA), 160'd0);
        else check("i_rdata", 160'(bus.I_READDATA), 160'(i_exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.I_READ = 1'b0; bus.I_ADDRESS = 6'd0;
    bus.D_READ = 1'b0; bus.D_WRITE = 1'b0; bus.D_ADDRESS = 6'd0; bus.D_WRITEDATA = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_mem", {bus.M_READ, bus.M_WRITE, bus.M_ADDRESS, bus.M_WRITEDATA}, 160'd0);
    check("rst_cache", {bus.I_READDATA, bus.D_READDATA}, 160'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single data read, instruction block, stalled data write.
    d_access(1'b0, 6'h05, 32'd0, 3);
    i_access(6'h02, 6);
    stall_n = 2; wr_cycles = 0;
    d_access(1'b1, 6'h3F, 32'hDEADBEEF, 5);
    stall_n = 0;
    check("wr_hold", 160'(wr_cycles), 160'd3);

    // Fresh reset so the first tie follows DATA_FIRST.
    rst_n = 1'b0; d_model = 32'd0;
    @(posedge clk); #1 rst_n = 1'b1;
    fork
      d_access(1'b0, 6'h05, 32'd0, 3);
      i_access(6'h02, 9);
    join
    d_access(1'b0, 6'h11, 32'd0, 3);
    // Data was granted last, so this tie goes to the instruction side.
    fork
      d_access(1'b0, 6'h20, 32'd0, 9);
      i_access(6'h3C, 6);
    join

    // Reset during beat 2: beats 0 and 1 complete, then the fetch restarts.
    for (int k = 0; k < 2; k++) begin
      mtx_t t;
      t.wr = 1'b0; t.addr = {1'b0, 6'h15, 2'(k)}; t.wd = 32'd0;
      mem_i_q.push_back(t);
    end
    fork
      i_access(6'h15, -1);
      begin
        repeat (3) @(posedge clk);
        #1 check("beat2_addr", 160'(bus.M_ADDRESS), 160'h056);
        rst_n = 1'b0;
        #1 check("rst_now_mem", {bus.M_READ, bus.M_WRITE, bus.M_ADDRESS, bus.M_WRITEDATA,
                                 bus.I_BUSYWAIT, bus.D_BUSYWAIT}, 160'd0);
        check("rst_now_cache", {bus.I_READDATA, bus.D_READDATA}, 160'd0);
        @(posedge clk); #1 rst_n = 1'b1;
      end
    join

    repeat (3) @(posedge clk);
    check("left_mem", 160'(mem_d_q.size() + mem_i_q.size()), 160'd0);
    check("left_rdata", 160'(d_exp_q.size() + i_exp_q.size()), 160'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
